// File: rtl/modinv_sched.sv
// Round-robin scheduler in front of one shared, non-pipelined modular-inverse unit.
// Zero operands are answered locally and every launch is bounded by a watchdog.
`ifndef WORDSZ
`define WORDSZ 32
`endif
`ifndef RFSZLOG2
`define RFSZLOG2 5
`endif

module modinv_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = `WORDSZ*4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*`WORDSZ-1:0]      req_a,
    input  logic [NREQ*`RFSZLOG2-1:0]    req_rn,
    output logic [NREQ-1:0]              req_ready,
    output logic                         inv_en,
    output logic [`WORDSZ-1:0]           inv_a,
    output logic [`RFSZLOG2-1:0]         inv_rn,
    input  logic                         inv_done,
    input  logic [`WORDSZ-1:0]           inv_res,
    input  logic [`RFSZLOG2-1:0]         inv_rn_o,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [$clog2(NREQ)-1:0]      wb_id,
    output logic [`RFSZLOG2-1:0]         wb_rn,
    output logic [`WORDSZ-1:0]           wb_res,
    output logic                         wb_err,
    output logic                         busy,
    output logic                         err
);
    localparam int W   = `WORDSZ;
    localparam int RW  = `RFSZLOG2;
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    state_t          state_nx;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;
    logic [NREQ-1:0] grant;
    logic [W-1:0]    a_q;
    logic [RW-1:0]   rn_q;
    logic [CW-1:0]   wcnt;
    logic [W-1:0]    a_sel;
    logic [RW-1:0]   rn_sel;
    logic            accept;
    logic            term;

    // Search upward from ptr; iterating downward lets the closest hit win.
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
        if (gnt_any) grant[gnt_id] = 1'b1;
    end

    assign a_sel     = req_a[gnt_id*W +: W];
    assign rn_sel    = req_rn[gnt_id*RW +: RW];
    assign accept    = (state == IDLE) && gnt_any;
    assign term      = (wcnt == CW'(TIMEOUT - 1));
    assign req_ready = (state == IDLE) ? grant : '0;
    assign inv_en    = (state == ISSUE);
    assign inv_a     = inv_en ? a_q : '0;
    assign inv_rn    = inv_en ? rn_q : '0;
    assign wb_valid  = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = (a_sel == '0) ? RESP : ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT:  if (inv_done || term) state_nx = RESP;
            RESP:  if (wb_ready) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            a_q    <= '0;
            rn_q   <= '0;
            wcnt   <= '0;
            wb_id  <= '0;
            wb_rn  <= '0;
            wb_res <= '0;
            wb_err <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= a_sel;
                        rn_q  <= rn_sel;
                        wb_id <= gnt_id;
                        ptr   <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                        if (a_sel == '0) begin
                            wb_res <= '0;
                            wb_err <= 1'b0;
                            wb_rn  <= rn_sel;
                        end
                    end
                end
                ISSUE: wcnt <= '0;
                WAIT: begin
                    // A completion on the terminal count still counts as success.
                    if (inv_done) begin
                        wb_res <= inv_res;
                        wb_rn  <= inv_rn_o;
                        wb_err <= 1'b0;
                    end else if (term) begin
                        err    <= 1'b1;
                        wb_res <= '0;
                        wb_err <= 1'b1;
                        wb_rn  <= rn_q;
                    end else begin
                        wcnt <= wcnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/modinv_sched.md
# modinv_sched

Scheduler that shares one non-pipelined modular-inverse unit between `NREQ` requesters, such as issue lanes or register-file writeback sources. It performs round-robin grant and launches the unit with a single-cycle enable. It captures the unit's single-cycle result pulse and returns it on a valid/ready writeback port, tagged with the requester id. A zero operand is answered locally, because the inverse unit never terminates on zero. A watchdog bounds every launch.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, `` `WORDSZ*4 ``: maximum WAIT cycles before an operation is aborted.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request valid, one bit per requester.
- `req_a`  in  NREQ*`WORDSZ`  operands; requester i uses `[i*WORDSZ +: WORDSZ]`.
- `req_rn`  in  NREQ*`RFSZLOG2`  destination register numbers; requester i uses `[i*RFSZLOG2 +: RFSZLOG2]`.
- `req_ready`  out  NREQ  one-hot grant; a request is accepted when valid&ready.
- `inv_en`  out  1  launch pulse to the inverse unit.
- `inv_a`  out  `WORDSZ`  operand to the unit.
- `inv_rn`  out  `RFSZLOG2`  register number to the unit.
- `inv_done`  in  1  single-cycle result pulse from the unit.
- `inv_res`  in  `WORDSZ`  result, valid only while `inv_done` is high.
- `inv_rn_o`  in  `RFSZLOG2`  returned register number, valid only with `inv_done`.
- `wb_valid`  out  1  writeback valid.
- `wb_ready`  in  1  writeback ready.
- `wb_id`  out  $clog2(NREQ)  id of the requester being answered.
- `wb_rn`  out  `RFSZLOG2`  destination register number.
- `wb_res`  out  `WORDSZ`  inverse result.
- `wb_err`  out  1  the result was produced by a timeout abort.
- `busy`  out  1  state != IDLE.
- `err`  out  1  sticky timeout flag, cleared only by reset.

## Operation
- Clock and reset: single clock `clk`; `rst_n` is asynchronous and active-low.
- States:
  - IDLE: arbitrate among the requesters.
  - ISSUE: drive the single `inv_en` cycle.
  - WAIT: wait for `inv_done`.
  - RESP: hold the writeback until accepted.
- IDLE arbitration:
  - `req_ready` is the one-hot round-robin choice among the asserted `req_valid` bits, searching from pointer `ptr` upward with wrap.
  - `req_ready` is all-zero in every other state, and in IDLE when no request is valid.
- On accept of requester g:
  - Latch `a`, `rn` and `id=g`.
  - Set `ptr = (g+1) mod NREQ`; the pointer changes only on accept.
  - If `a == 0`: load `wb_res=0`, `wb_err=0`, `wb_rn=rn`, `wb_id=g`, and go to RESP without launching the unit.
  - Otherwise go to ISSUE.
- ISSUE: `inv_en=1`, `inv_a=a`, `inv_rn=rn` for exactly one cycle. Clear the watchdog counter `wcnt` and go to WAIT.
- WAIT:
  - On `inv_done`: capture `inv_res` into `wb_res` and `inv_rn_o` into `wb_rn`, set `wb_err=0`, go to RESP.
  - Otherwise increment `wcnt`. When `wcnt == TIMEOUT-1` with no `inv_done`: set `err=1`, `wb_res=0`, `wb_err=1`, `wb_rn=rn`, go to RESP.
- RESP:
  - `wb_valid=1`.
  - `wb_id`, `wb_rn`, `wb_res` and `wb_err` stay stable until `wb_ready`.
  - On `wb_ready`, go to IDLE.
- An `inv_done` arriving in any state other than WAIT is discarded. This covers a late completion after a timeout.
- `inv_a` and `inv_rn` are zero whenever `inv_en` is 0.
- `wcnt` width is $clog2(TIMEOUT)+1.

## Timing
- Reset values: all outputs 0. Also `state=IDLE`, `ptr=0`, `wcnt=0`.
- Reset is asynchronous. Asserting it mid-operation abandons the operation with no writeback. The inverse unit shares `rst_n`.
- Accept in cycle T: `inv_en` is high in T+1, and the state is WAIT from T+2.
- `inv_done` in cycle D: `wb_valid` is high from D+1.
- Zero-operand accept in T: `wb_valid` is high in T+1.
- Timeout: `wb_valid` is high in cycle (T+2)+TIMEOUT, with `wb_err=1`.
- Writeback accepted in R (`wb_valid` & `wb_ready`): IDLE in R+1, and the next accept is possible in R+1.
- Simultaneous `inv_done` and the watchdog terminal count: `inv_done` wins, giving `wb_err=0` with `err` unchanged.
- Requests deasserted before grant are not recorded. No request is dropped once accepted.

## Test plan
- Single request: requester 2, `a=3`, `rn=5`. The stub unit returns `res=0xABC`, `rn=5` 12 cycles after `inv_en`. Required:
  - `inv_en` high exactly once, carrying 3 and 5.
  - `wb_valid` with `wb_id=2`, `wb_rn=5`, `wb_res=0xABC`, `wb_err=0`, 13 cycles after `inv_en`.
- Fairness: all four requesters held valid for 8 operations. Required: grant order 0,1,2,3,0,1,2,3, each requester answered with its own `rn`.
- Zero operand: requester 1, `a=0`, `rn=7`. Required: `inv_en` never asserts; `wb_res=0`, `wb_rn=7` one cycle after accept.
- Backpressure: hold `wb_ready=0` for 20 cycles during RESP. Required:
  - Writeback fields stay stable.
  - `req_ready` stays 0 and no new `inv_en` is issued.
  - The transaction completes once `wb_ready` rises.
- Timeout: the stub never asserts `inv_done`, with `TIMEOUT=16`. Required:
  - `wb_err=1`, `wb_res=0`, `err=1`, 16 cycles after WAIT entry.
  - A later stray `inv_done` in IDLE produces no writeback.
- Reset mid-WAIT: assert `rst_n=0` 5 cycles into WAIT. Required: all outputs 0 immediately, and no writeback follows after release.
